// File: rtl/pipe_ex_stage_md_if.sv
// ID->EX bus: ID-stage instruction fields and forwarding sources in,
// EX results and the stall request out.
interface pipe_ex_stage_md_if #(
  parameter int W  = 32,
  parameter int WN = 5
);
  logic          id_valid, id_wreg, id_m2reg, id_wmem;
  logic [3:0]    id_aluc;
  logic [1:0]    id_md_op, id_sel_a, id_sel_b;
  logic [WN-1:0] id_wn;
  logic [W-1:0]  id_qa, id_qb, id_imm;
  logic [1:0]    id_jump_type;
  logic [W-1:0]  id_jump_pc;
  logic          flush;
  logic [W-1:0]  mem_alu_result, wb_data;

  logic          ex_valid, ex_wreg, ex_m2reg, ex_wmem;
  logic [WN-1:0] ex_wn;
  logic [W-1:0]  ex_result, ex_qb;
  logic          ex_zero;
  logic [1:0]    ex_jump_type;
  logic [W-1:0]  ex_jump_pc;
  logic          ex_busy;

  modport master (
    output id_valid, id_wreg, id_m2reg, id_wmem, id_aluc, id_md_op, id_sel_a, id_sel_b,
           id_wn, id_qa, id_qb, id_imm, id_jump_type, id_jump_pc, flush,
           mem_alu_result, wb_data,
    input  ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_wn, ex_result, ex_qb, ex_zero,
           ex_jump_type, ex_jump_pc, ex_busy
  );

  modport slave (
    input  id_valid, id_wreg, id_m2reg, id_wmem, id_aluc, id_md_op, id_sel_a, id_sel_b,
           id_wn, id_qa, id_qb, id_imm, id_jump_type, id_jump_pc, flush,
           mem_alu_result, wb_data,
    output ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_wn, ex_result, ex_qb, ex_zero,
           ex_jump_type, ex_jump_pc, ex_busy
  );
endinterface

// File: rtl/pipe_ex_stage_md.sv
// EX stage: ID/EX register with stall/flush, operand forwarding, 1-cycle ALU
// and an iterative shift-add multiplier / restoring divider (W+2 cycles).
module pipe_ex_stage_md #(
  parameter int W  = 32,
  parameter int WN = 5
) (
  input logic               clk,
  input logic               clr,
  pipe_ex_stage_md_if.slave bus
);
  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);

  typedef struct packed {
    logic          valid, wreg, m2reg, wmem;
    logic [3:0]    aluc;
    logic [1:0]    mdOp, selA, selB;
    logic [WN-1:0] wn;
    logic [W-1:0]  qa, qb, imm;
    logic [1:0]    jumpType;
    logic [W-1:0]  jumpPc;
  } idEx_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mdState_t;

  idEx_t    r, idIn;
  mdState_t state;
  logic [SW-1:0] cnt;
  logic [W-1:0]  opA, opB, acc;      // mul: multiplicand/multiplier/product; div: quotient/divisor/remainder
  logic [W-1:0]  alua, alub, aluRes, mdRes, result;
  logic [SW-1:0] sh;
  logic [W:0]    trial;
  logic          fits, mdStart, exBusy, exValid;

  // Gather ID-stage fields into one record
  always_comb begin
    idIn          = '0;
    idIn.valid    = bus.id_valid;
    idIn.wreg     = bus.id_wreg;
    idIn.m2reg    = bus.id_m2reg;
    idIn.wmem     = bus.id_wmem;
    idIn.aluc     = bus.id_aluc;
    idIn.mdOp     = bus.id_md_op;
    idIn.selA     = bus.id_sel_a;
    idIn.selB     = bus.id_sel_b;
    idIn.wn       = bus.id_wn;
    idIn.qa       = bus.id_qa;
    idIn.qb       = bus.id_qb;
    idIn.imm      = bus.id_imm;
    idIn.jumpType = bus.id_jump_type;
    idIn.jumpPc   = bus.id_jump_pc;
  end

  // ID/EX register: hold while busy, bubble on flush, otherwise load
  always_ff @(posedge clk) begin
    if (clr)          r <= '0;
    else if (!exBusy) r <= bus.flush ? '0 : idIn;
  end

  // Forwarding muxes; sources are live during the EX cycle
  always_comb begin
    case (r.selA)
      2'd0:    alua = r.qa;
      2'd1:    alua = r.imm;
      2'd2:    alua = bus.mem_alu_result;
      default: alua = bus.wb_data;
    endcase
    case (r.selB)
      2'd0:    alub = r.qb;
      2'd1:    alub = r.imm;
      2'd2:    alub = bus.mem_alu_result;
      default: alub = bus.wb_data;
    endcase
  end

  assign sh = alua[SW-1:0];

  // Single-cycle ALU
  always_comb begin
    case (r.aluc)
      4'h0:    aluRes = alua + alub;
      4'h1:    aluRes = alua - alub;
      4'h2:    aluRes = alua & alub;
      4'h3:    aluRes = alua | alub;
      4'h4:    aluRes = alua ^ alub;
      4'h5:    aluRes = alub << sh;
      4'h6:    aluRes = alub >> sh;
      4'h7:    aluRes = $unsigned($signed(alub) >>> sh);
      4'h8:    aluRes = alub << (W / 2);
      4'h9:    aluRes = {{(W-1){1'b0}}, $signed(alua) < $signed(alub)};
      4'hA:    aluRes = {{(W-1){1'b0}}, alua < alub};
      default: aluRes = '0;
    endcase
  end

  // Restoring-divide step: shift next dividend bit into the partial remainder.
  // b==0 always "fits", which yields an all-ones quotient and remainder = a.
  assign trial = {acc, opA[W-1]};
  assign fits  = trial >= {1'b0, opB};

  assign mdStart = r.valid && (r.mdOp != 2'b00);

  // Mul/div sequencer: capture forwarded operands, iterate W times, present result
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      opA   <= '0;
      opB   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: if (mdStart) begin
          opA   <= alua;
          opB   <= alub;
          acc   <= '0;
          cnt   <= CNT_LAST;
          state <= RUN;
        end
        RUN: begin
          if (r.mdOp == 2'b01) begin
            acc <= acc + (opB[0] ? opA : '0);
            opA <= opA << 1;
            opB <= opB >> 1;
          end else begin
            acc <= fits ? (trial[W-1:0] - opB) : trial[W-1:0];
            opA <= {opA[W-2:0], fits};
          end
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mdRes   = (r.mdOp == 2'b10) ? opA : acc;
  assign exBusy  = (state == RUN) || (state == IDLE && mdStart);
  assign exValid = (state == DONE) || (state == IDLE && r.valid && r.mdOp == 2'b00);
  assign result  = (state == DONE) ? mdRes : aluRes;

  assign bus.ex_busy      = exBusy;
  assign bus.ex_valid     = exValid;
  assign bus.ex_wreg      = exValid & r.wreg;
  assign bus.ex_m2reg     = exValid & r.m2reg;
  assign bus.ex_wmem      = exValid & r.wmem;
  assign bus.ex_wn        = r.wn;
  assign bus.ex_result    = result;
  assign bus.ex_zero      = (result == '0);
  assign bus.ex_qb        = r.qb;
  assign bus.ex_jump_type = r.jumpType;
  assign bus.ex_jump_pc   = r.jumpPc;
endmodule
